// File: rtl/ctrl_pkg.sv
// Shared types and constants for the writeback/sequencing controller.
package ctrl_pkg;

  localparam int unsigned INST_W  = 9;
  localparam int unsigned OPC_MSB = 8;
  localparam int unsigned OPC_LSB = 4;

  typedef enum logic [4:0] {
    OP_NOP    = 5'h00,
    OP_MOV    = 5'h01,
    OP_LDR    = 5'h02,
    OP_STR    = 5'h03,
    OP_ALU_LO = 5'h04,
    OP_ALU_HI = 5'h0F,
    OP_LDA    = 5'h10,
    OP_HALT   = 5'h1F
  } opcode_t;

  typedef enum logic [1:0] {
    StIdle,
    StMem,
    StWb,
    StHalt
  } state_t;

  function automatic logic is_alu(logic [4:0] opc);
    return (opc >= OP_ALU_LO) && (opc <= OP_ALU_HI);
  endfunction

endpackage

// File: rtl/wb_ctrl_if.sv
// Instruction handshake, memory strobes and register-file controls of wb_ctrl.
interface wb_ctrl_if
  import ctrl_pkg::*;
#(
  parameter int unsigned A     = 4,
  parameter int unsigned CNT_W = 16
) ();

  logic              inst_valid;
  logic [INST_W-1:0] inst;
  logic              inst_ready;
  logic              mem_ready;
  logic              Mem_Read;
  logic              Mem_Write;
  logic              Acc_Load;
  logic              Write_En;
  logic              from_ALU;
  logic              from_Acc;
  logic              from_Mem;
  logic [A-1:0]      address;
  logic              Done;
  logic              illegal;
  logic              mem_err;
  logic [CNT_W-1:0]  retired;

  modport master (
    output inst_valid, inst, mem_ready,
    input  inst_ready, Mem_Read, Mem_Write, Acc_Load, Write_En,
    input  from_ALU, from_Acc, from_Mem, address, Done, illegal, mem_err, retired
  );

  modport slave (
    input  inst_valid, inst, mem_ready,
    output inst_ready, Mem_Read, Mem_Write, Acc_Load, Write_En,
    output from_ALU, from_Acc, from_Mem, address, Done, illegal, mem_err, retired
  );

endinterface

// File: rtl/mem_timer.sv
// Counts MEM-state cycles; expired is high during the TIMEOUT-th counted cycle.
module mem_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = $clog2(TIMEOUT);
  localparam logic [W-1:0] LastCnt = W'(TIMEOUT - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LastCnt)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LastCnt);

endmodule

// File: rtl/wb_ctrl.sv
// Writeback/sequencing controller: accepts decoded instructions, runs the data-memory
// access and drives register-file write enable, source selects and address.
module wb_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned A       = 4,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic       clk,
  input  logic       Reset,
  wb_ctrl_if.slave   bus
);

  state_t            state_q, state_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [CNT_W-1:0]  retired_q;
  logic              done_q, illegal_q, mem_err_q;
  logic              retire, set_done, set_illegal, set_mem_err;
  logic              tmr_clr, tmr_en, tmr_expired;
  logic              accept;
  logic [4:0]        opc_in, opc_q;

  assign opc_in = bus.inst[OPC_MSB:OPC_LSB];
  assign opc_q  = inst_q[OPC_MSB:OPC_LSB];

  assign bus.inst_ready = (state_q == StIdle) && !Reset;
  assign accept         = bus.inst_valid && bus.inst_ready;

  mem_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_mem_timer (
    .clk     (clk),
    .Reset   (Reset),
    .clear   (tmr_clr),
    .enable  (tmr_en),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d     = state_q;
    inst_d      = inst_q;
    retire      = 1'b0;
    set_done    = 1'b0;
    set_illegal = 1'b0;
    set_mem_err = 1'b0;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          inst_d  = bus.inst;
          tmr_clr = 1'b1;
          if (opc_in == OP_NOP) begin
            retire = 1'b1;
          end else if ((opc_in == OP_MOV) || (opc_in == OP_LDA) || is_alu(opc_in)) begin
            state_d = StWb;
          end else if ((opc_in == OP_LDR) || (opc_in == OP_STR)) begin
            state_d = StMem;
          end else if (opc_in == OP_HALT) begin
            state_d  = StHalt;
            retire   = 1'b1;
            set_done = 1'b1;
          end else begin
            set_illegal = 1'b1;
          end
        end
      end
      StMem: begin
        tmr_en = 1'b1;
        // Completion takes priority over a timeout landing in the same cycle.
        if (bus.mem_ready) begin
          if (opc_q == OP_LDR) begin
            state_d = StWb;
          end else begin
            state_d = StIdle;
            retire  = 1'b1;
          end
        end else if (tmr_expired) begin
          state_d     = StIdle;
          set_mem_err = 1'b1;
        end
      end
      StWb: begin
        state_d = StIdle;
        retire  = 1'b1;
      end
      StHalt: begin
        state_d = StHalt;
      end
    endcase
  end

  always_comb begin
    bus.Mem_Read  = 1'b0;
    bus.Mem_Write = 1'b0;
    bus.Acc_Load  = 1'b0;
    bus.Write_En  = 1'b0;
    bus.from_ALU  = 1'b0;
    bus.from_Acc  = 1'b0;
    bus.from_Mem  = 1'b0;
    unique case (state_q)
      StMem: begin
        bus.Mem_Read  = (opc_q == OP_LDR);
        bus.Mem_Write = (opc_q == OP_STR);
      end
      StWb: begin
        if (opc_q == OP_MOV) begin
          bus.Write_En = 1'b1;
          bus.from_Acc = 1'b1;
        end else if (opc_q == OP_LDR) begin
          bus.Write_En = 1'b1;
          bus.from_Mem = 1'b1;
          bus.Mem_Read = 1'b1;
        end else if (opc_q == OP_LDA) begin
          bus.Acc_Load = 1'b1;
        end else if (is_alu(opc_q)) begin
          bus.Write_En = 1'b1;
          bus.from_ALU = 1'b1;
        end
      end
      StIdle, StHalt: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= StIdle;
      inst_q    <= '0;
      retired_q <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      done_q    <= done_q | set_done;
      illegal_q <= illegal_q | set_illegal;
      mem_err_q <= mem_err_q | set_mem_err;
      if (retire && (retired_q != {CNT_W{1'b1}})) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  assign bus.address = inst_q[A-1:0];
  assign bus.Done    = done_q;
  assign bus.illegal = illegal_q;
  assign bus.mem_err = mem_err_q;
  assign bus.retired = retired_q;

endmodule

// File: doc/wb_ctrl.md
Name: wb_ctrl

Overview:
- Writeback/sequencing controller directly upstream of the register file.
- Accepts decoded 9-bit instructions through a valid/ready handshake and sequences the multi-cycle data-memory access.
- Drives the register file's Write_En, source-select lines (from_ALU / from_Acc / from_Mem) and 4-bit address.
- Also drives the accumulator load strobe, memory strobes, a retire counter and sticky status flags.

Parameters:
- A, 4, register-address width; equals inst[3:0] width and matches the register file's A.
- TIMEOUT, 16, maximum MEM-state cycles waiting for mem_ready before abort; minimum 2.
- CNT_W, 16, retire counter width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- inst_valid  in  1  upstream instruction valid.
- inst  in  9  instruction; [8:4] opcode, [3:0] register address.
- inst_ready  out  1  = (state==IDLE) && !Reset.
- mem_ready  in  1  data memory completion, sampled in MEM.
- Mem_Read  out  1  data memory read strobe.
- Mem_Write  out  1  data memory write strobe.
- Acc_Load  out  1  accumulator loads register-file DataOut this cycle.
- Write_En  out  1  register-file write enable.
- from_ALU  out  1  register-file source select: ALU.
- from_Acc  out  1  register-file source select: accumulator.
- from_Mem  out  1  register-file source select: memory.
- address  out  A  latched inst[3:0]; valid in every non-IDLE state.
- Done  out  1  sticky; HALT retired.
- illegal  out  1  sticky; unknown opcode accepted.
- mem_err  out  1  sticky; memory timeout.
- retired  out  CNT_W  saturating retire count.

Behaviour:
- Reset (async):
  - State goes to IDLE.
  - Latched instruction, timer, retired, Done, illegal and mem_err all clear to 0.
  - All strobes and selects are 0.
  - Reset asserted mid-MEM or mid-WB aborts the operation: no write, no retire.
- States: IDLE, MEM, WB, HALT. All outputs decode from state plus the latched opcode. No output depends combinationally on inst.
- Accept: in IDLE, inst_valid && inst_ready at edge N latches inst. Opcode dispatch:
  - 5'h00 NOP: stay IDLE; retire at N.
  - 5'h01 MOV (reg <= Acc): go WB. In WB: Write_En=1, from_Acc=1.
  - 5'h02 LDR (reg <= Mem): go MEM with Mem_Read=1. On mem_ready, go WB: Write_En=1, from_Mem=1, Mem_Read held 1.
  - 5'h03 STR: go MEM with Mem_Write=1. On mem_ready, go IDLE and retire. No register write.
  - 5'h04..5'h0F ALU: go WB. In WB: Write_En=1, from_ALU=1.
  - 5'h10 LDA (Acc <= reg): go WB. In WB: Acc_Load=1, Write_En=0.
  - 5'h1F HALT: go HALT and retire. Done=1. HALT is absorbing until Reset; inst_ready=0.
  - Any other opcode: set illegal, stay IDLE, no retire.
- Select rules:
  - Exactly one of from_ALU, from_Acc, from_Mem is 1 whenever Write_En=1.
  - All three are 0 when Write_En=0.
- WB is always one cycle, then IDLE with retire. The register-file write lands at the WB-ending edge.
- Latency:
  - MOV/ALU/LDA: accepted at N, WB during N+1, next accept at N+2.
  - LDR with mem_ready high on the first MEM cycle: MEM N+1, WB N+2, next accept at N+3.
- Timeout:
  - Timer clears on MEM entry and increments each MEM cycle.
  - If mem_ready is still low in the TIMEOUT-th MEM cycle: set mem_err, go IDLE, no write, no retire.
  - If mem_ready is high in that same cycle, completion wins.
- retired saturates at all-ones; it does not wrap.
- Sticky flags clear only on Reset.

Decomposition:
- Shared package ctrl_pkg holds:
  - typedef enum logic [4:0] opcode_t: OP_NOP, OP_MOV, OP_LDR, OP_STR, OP_ALU_LO=5'h04, OP_ALU_HI=5'h0F, OP_LDA, OP_HALT.
  - typedef enum logic [1:0] state_t.
  - localparams INST_W=9, OPC_MSB=8, OPC_LSB=4.
- One sub-module, mem_timer: a TIMEOUT counter with clear/enable inputs and an expired output.

Test Plan:
1. Reset, then accept inst 9'h012 (MOV r2) -> one cycle later Write_En=1, from_Acc=1, address=2; retired=1; inst_ready returns to 1 the following cycle.
2. LDR r5 (9'h025), mem_ready low for 3 MEM cycles then high -> Mem_Read=1 for 4 MEM cycles plus 1 WB cycle; WB has Write_En=1, from_Mem=1, address=5.
3. STR with mem_ready held low, TIMEOUT=16 -> after 16 MEM cycles mem_err=1, state IDLE, Write_En never 1, retired unchanged.
4. Opcode 5'h15, then ALU r7 (9'h047) -> illegal=1, first not retired; second gives Write_En=1, from_ALU=1, address=7; retired=1.
5. HALT (9'h1F0), then inst_valid held high -> Done=1, inst_ready=0 indefinitely; Reset clears Done and restores inst_ready=1.
6. Reset asserted mid-MEM of LDR -> all outputs 0 immediately (asynchronous); no write occurs; retired=0; CNT_W=2 with 5 NOPs -> retired saturates at 3.
